aes_encrypt_iter: RTL and testbench

- Iterative AES-128 encryption datapath that sits directly downstream of key_expander and consumes its eleven 128-bit round keys.
- Performs one AES round per clock: initial AddRoundKey, then rounds 1..10, with round 10 omitting MixColumns.
- Uses a valid/ready handshake on input and output.
- Feeds the cipher output stage and the AES system bench.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_encrypt_iter.sv | 152 +++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and round-function helpers.
package aes_pkg;

  localparam int unsigned AES_DW = 128;
  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_NK = 11;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word is {a0,a1,a2,a3} with a0 in the top byte (row 0).
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte r+4c sits at bits [127-8(r+4c) -: 8]; row r rotates left by r.
  function automatic logic [AES_DW-1:0] shift_rows(input logic [AES_DW-1:0] s);
    logic [AES_DW-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (table lookup), one byte per instance.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] sub_c
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 occupies the top byte, so the offset is (255-a)*8 = {~a,3'b0}.
  assign sub_c = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock, valid/ready on both sides.
// Define AES_KEY_CAPTURE_EN to latch all round keys into a local bank on accept.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned DW = AES_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] plaintext,
  input  logic [DW-1:0] expanded_key_1,
  input  logic [DW-1:0] expanded_key_2,
  input  logic [DW-1:0] expanded_key_3,
  input  logic [DW-1:0] expanded_key_4,
  input  logic [DW-1:0] expanded_key_5,
  input  logic [DW-1:0] expanded_key_6,
  input  logic [DW-1:0] expanded_key_7,
  input  logic [DW-1:0] expanded_key_8,
  input  logic [DW-1:0] expanded_key_9,
  input  logic [DW-1:0] expanded_key_10,
  input  logic [DW-1:0] expanded_key_11,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ciphertext,
  output logic          busy
);

  if (NR != AES_NR || DW != AES_DW) begin : g_param_check
    $error("aes_encrypt_iter: only NR=10 and DW=128 are supported");
  end

  aes_state_e        state_q, state_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [AES_DW-1:0] state_reg, state_reg_d, ciphertext_d;
  logic              in_ready_d, out_valid_d, busy_d;
  logic [AES_DW-1:0] key_live [AES_NK];
  logic [AES_DW-1:0] keys [AES_NK];
  logic [AES_DW-1:0] round_key, sb, sr, mc, round_out;

  assign key_live[0]  = expanded_key_1;
  assign key_live[1]  = expanded_key_2;
  assign key_live[2]  = expanded_key_3;
  assign key_live[3]  = expanded_key_4;
  assign key_live[4]  = expanded_key_5;
  assign key_live[5]  = expanded_key_6;
  assign key_live[6]  = expanded_key_7;
  assign key_live[7]  = expanded_key_8;
  assign key_live[8]  = expanded_key_9;
  assign key_live[9]  = expanded_key_10;
  assign key_live[10] = expanded_key_11;

`ifdef AES_KEY_CAPTURE_EN
  logic [AES_DW-1:0] key_bank [AES_NK];

  // Snapshot every round key on the accepting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AES_NK; i++) key_bank[i] <= '0;
    end else if (in_valid && in_ready) begin
      for (int i = 0; i < AES_NK; i++) key_bank[i] <= key_live[i];
    end
  end

  // Round 0 is applied on the accepting cycle itself, before the bank loads.
  always_comb begin
    keys    = key_bank;
    keys[0] = key_live[0];
  end
`else
  assign keys = key_live;
`endif

  always_comb begin
    round_key = '0;
    for (int i = 1; i < AES_NK; i++) begin
      if (rnd_q == 4'(i)) round_key = keys[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a     (state_reg[8*i +: 8]),
      .sub_c (sb[8*i +: 8])
    );
  end

  assign sr = shift_rows(sb);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
  end

  // The final round skips MixColumns.
  assign round_out = ((rnd_q == 4'(AES_NR)) ? sr : mc) ^ round_key;

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    state_reg_d  = state_reg;
    ciphertext_d = ciphertext;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_reg_d = plaintext ^ keys[0];
          rnd_d       = 4'd1;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        state_reg_d = round_out;
        if (rnd_q == 4'(AES_NR)) begin
          ciphertext_d = round_out;
          rnd_d        = '0;
          state_d      = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      state_reg  <= '0;
      ciphertext <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      state_reg  <= state_reg_d;
      ciphertext <= ciphertext_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed scoreboard bench for aes_encrypt_iter; round keys come from a local
// key-schedule model built on an arithmetic (inverse + affine) S-box.
module tb_aes_encrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] ALT_PT = 128'hdeadbeefcafef00d0123456789abcdef;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] rk [11];
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  typedef struct {
    logic [127:0] ct;
    bit           differ;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;

  aes_encrypt_iter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .plaintext       (plaintext),
    .expanded_key_1  (rk[0]),
    .expanded_key_2  (rk[1]),
    .expanded_key_3  (rk[2]),
    .expanded_key_4  (rk[3]),
    .expanded_key_5  (rk[4]),
    .expanded_key_6  (rk[5]),
    .expanded_key_7  (rk[6]),
    .expanded_key_8  (rk[7]),
    .expanded_key_9  (rk[8]),
    .expanded_key_10 (rk[9]),
    .expanded_key_11 (rk[10]),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .ciphertext      (ciphertext),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] r, base, e, s;
    r    = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic set_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait (bounded) for in_ready, push the expectation on accept.
  task automatic accept_block(input string tag, input logic [127:0] pt,
                              input logic [127:0] key, input logic [127:0] exp,
                              input bit differ);
    int guard;
    exp_t e;
    set_keys(key);
    plaintext = pt;
    in_valid  = 1'b1;
    guard     = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    e.ct     = exp;
    e.differ = differ;
    sb_q.push_back(e);
    check({tag, "_busy"}, 128'(busy), 128'(1));
  endtask

  // Count edges (accept edge = 1) until out_valid rises, bounded.
  task automatic wait_out(input string tag, input int start, output int n);
    n = start;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_out_valid_seen"}, 128'(out_valid), 128'(1));
  endtask

  // Expects out_ready high: pop, compare, and confirm out_valid drops next cycle.
  task automatic take_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      if (e.differ) begin
        n_cmp++;
        assert (ciphertext !== e.ct) else begin
          n_bad++;
          $error("FAIL %s_ct_differs observed=%h expected=not %h", tag, ciphertext, e.ct);
        end
      end else begin
        check({tag, "_ct"}, ciphertext, e.ct);
      end
    end
    tick();
    check({tag, "_out_valid_drop"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    set_keys('0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_ct", ciphertext, 128'(0));
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 with out_ready already high, latency measured.
    out_ready = 1'b1;
    accept_block("c1", C1_PT, C1_KEY, C1_CT, 1'b0);
    check("c1_in_ready_low", 128'(in_ready), 128'(0));
    wait_out("c1", 1, lat);
    check("c1_latency", 128'(lat), 128'(11));
    take_out("c1");

    // All-zero key and plaintext.
    accept_block("zero", '0, '0, Z_CT, 1'b0);
    wait_out("zero", 1, lat);
    check("zero_latency", 128'(lat), 128'(11));
    take_out("zero");

    // Backpressure: hold out_ready low for 20 cycles.
    out_ready = 1'b0;
    accept_block("bp", C1_PT, C1_KEY, C1_CT, 1'b0);
    wait_out("bp", 1, lat);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold_valid", 128'(out_valid), 128'(1));
      check("bp_hold_ct", ciphertext, C1_CT);
      check("bp_hold_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    take_out("bp");
    check("bp_idle_in_ready", 128'(in_ready), 128'(1));

    // in_valid pulses at T+3 and T+11 must be ignored.
    accept_block("ign", C1_PT, C1_KEY, C1_CT, 1'b0);
    tick();
    tick();
    plaintext = ALT_PT;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("ign_out_valid_t11", 128'(out_valid), 128'(1));
    in_valid = 1'b1;
    take_out("ign");
    in_valid = 1'b0;
    check("ign_no_accept_busy", 128'(busy), 128'(0));
    check("ign_no_accept_ready", 128'(in_ready), 128'(1));
    tick();
    check("ign_still_idle", 128'(busy), 128'(0));
    check("ign_queue_empty", 128'(sb_q.size()), 128'(0));

    // Asynchronous reset during round 5 aborts the block.
    accept_block("rst", C1_PT, C1_KEY, C1_CT, 1'b0);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_ct", ciphertext, 128'(0));
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    accept_block("post_rst", C1_PT, C1_KEY, C1_CT, 1'b0);
    wait_out("post_rst", 1, lat);
    check("post_rst_latency", 128'(lat), 128'(11));
    take_out("post_rst");

    // Key bus changes to the all-zero schedule one cycle after accept.
`ifdef AES_KEY_CAPTURE_EN
    accept_block("keychg", C1_PT, C1_KEY, C1_CT, 1'b0);
`else
    accept_block("keychg", C1_PT, C1_KEY, C1_CT, 1'b1);
`endif
    tick();
    set_keys('0);
    wait_out("keychg", 2, lat);
    take_out("keychg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
